// File: rtl/side_info_parser.sv
// side_info_parser: deserialises a fixed 256-bit stereo side-info block (MSB first)
// into per-granule/channel fields and commits them all at once with a si_valid pulse.
`default_nettype none

module side_info_parser (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic                          axiid,
    input  logic                          axiiv,
    output logic [8:0]                    main_data_begin,
    output logic [1:0][3:0]               scfsi,
    output logic [1:0][1:0][11:0]         part2_3_length,
    output logic [1:0][1:0][8:0]          big_values,
    output logic [1:0][1:0][7:0]          global_gain,
    output logic [1:0][1:0][3:0]          scalefac_compress,
    output logic [1:0][1:0]               window_switching_flag,
    output logic [1:0][1:0]               mixed_block_flag,
    output logic [1:0][1:0]               preflag,
    output logic [1:0][1:0]               scalefac_scale,
    output logic [1:0][1:0]               count1table_select,
    output logic [1:0][1:0][1:0]          block_type,
    output logic [1:0][1:0][2:0][4:0]     table_select,
    output logic [1:0][1:0][2:0][2:0]     subblock_gain,
    output logic [1:0][1:0][3:0]          region0_count,
    output logic [1:0][1:0][2:0]          region1_count,
    output logic                          si_valid
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] PARSE = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    logic [1:0]   state;
    logic [7:0]   bit_cnt;
    logic [255:0] shadow;
    logic [255:0] frame;
    logic         accept;
    logic         last_bit;

    // The 256th bit wins over a coincident start so the frame still completes.
    assign accept   = (state == PARSE) && axiiv && (!start || (bit_cnt == 8'd255));
    assign last_bit = accept && (bit_cnt == 8'd255);
    assign frame    = {shadow[254:0], axiid};
    assign si_valid = (state == DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            bit_cnt <= 8'd0;
            shadow  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state   <= PARSE;
                        bit_cnt <= 8'd0;
                    end
                end
                PARSE: begin
                    if (last_bit) begin
                        state   <= DONE;
                        bit_cnt <= 8'd0;
                        shadow  <= frame;
                    end else if (start) begin
                        bit_cnt <= 8'd0;
                    end else if (accept) begin
                        bit_cnt <= bit_cnt + 8'd1;
                        shadow  <= frame;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    logic [8:0]                n_mdb;
    logic [1:0][3:0]           n_scfsi;
    logic [1:0][1:0][11:0]     n_p23;
    logic [1:0][1:0][8:0]      n_bv;
    logic [1:0][1:0][7:0]      n_gg;
    logic [1:0][1:0][3:0]      n_sfc;
    logic [1:0][1:0]           n_wsf, n_mixed, n_pre, n_sfs, n_c1;
    logic [1:0][1:0][1:0]      n_bt;
    logic [1:0][1:0][2:0][4:0] n_ts;
    logic [1:0][1:0][2:0][2:0] n_sbg;
    logic [1:0][1:0][3:0]      n_r0;
    logic [1:0][1:0][2:0]      n_r1;
    logic [58:0]               grp;
    logic [21:0]               body;

    // Fixed layout: 9 mdb + 3 private + 8 scfsi, then four 59-bit groups from bit 235 down.
    always_comb begin
        n_mdb      = frame[255:247];
        n_scfsi[0] = frame[243:240];
        n_scfsi[1] = frame[239:236];
        n_p23 = '0;  n_bv = '0;    n_gg = '0;  n_sfc = '0;
        n_wsf = '0;  n_mixed = '0; n_pre = '0; n_sfs = '0; n_c1 = '0;
        n_bt  = '0;  n_ts = '0;    n_sbg = '0; n_r0 = '0;  n_r1 = '0;
        grp   = '0;
        body  = '0;
        for (int g = 0; g < 4; g++) begin
            grp  = frame[235 - 59*g -: 59];
            body = grp[24:3];
            n_p23[g[1]][g[0]] = grp[58:47];
            n_bv [g[1]][g[0]] = grp[46:38];
            n_gg [g[1]][g[0]] = grp[37:30];
            n_sfc[g[1]][g[0]] = grp[29:26];
            n_wsf[g[1]][g[0]] = grp[25];
            n_pre[g[1]][g[0]] = grp[2];
            n_sfs[g[1]][g[0]] = grp[1];
            n_c1 [g[1]][g[0]] = grp[0];
            if (grp[25]) begin
                n_bt   [g[1]][g[0]]    = body[21:20];
                n_mixed[g[1]][g[0]]    = body[19];
                n_ts   [g[1]][g[0]][0] = body[18:14];
                n_ts   [g[1]][g[0]][1] = body[13:9];
                n_sbg  [g[1]][g[0]][0] = body[8:6];
                n_sbg  [g[1]][g[0]][1] = body[5:3];
                n_sbg  [g[1]][g[0]][2] = body[2:0];
            end else begin
                n_ts[g[1]][g[0]][0] = body[21:17];
                n_ts[g[1]][g[0]][1] = body[16:12];
                n_ts[g[1]][g[0]][2] = body[11:7];
                n_r0[g[1]][g[0]]    = body[6:3];
                n_r1[g[1]][g[0]]    = body[2:0];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_data_begin       <= '0;
            scfsi                 <= '0;
            part2_3_length        <= '0;
            big_values            <= '0;
            global_gain           <= '0;
            scalefac_compress     <= '0;
            window_switching_flag <= '0;
            mixed_block_flag      <= '0;
            preflag               <= '0;
            scalefac_scale        <= '0;
            count1table_select    <= '0;
            block_type            <= '0;
            table_select          <= '0;
            subblock_gain         <= '0;
            region0_count         <= '0;
            region1_count         <= '0;
        end else if (last_bit) begin
            main_data_begin       <= n_mdb;
            scfsi                 <= n_scfsi;
            part2_3_length        <= n_p23;
            big_values            <= n_bv;
            global_gain           <= n_gg;
            scalefac_compress     <= n_sfc;
            window_switching_flag <= n_wsf;
            mixed_block_flag      <= n_mixed;
            preflag               <= n_pre;
            scalefac_scale        <= n_sfs;
            count1table_select    <= n_c1;
            block_type            <= n_bt;
            table_select          <= n_ts;
            subblock_gain         <= n_sbg;
            region0_count         <= n_r0;
            region1_count         <= n_r1;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_side_info_parser.sv
// tb_side_info_parser: encodes side-info frames from field values, serialises them into
// the parser and compares each committed block against a queue of expected fields.
`default_nettype none

module tb_side_info_parser;

    typedef struct {
        logic [8:0]                mdb;
        logic [1:0][3:0]           scfsi;
        logic [1:0][1:0][11:0]     p23;
        logic [1:0][1:0][8:0]      bv;
        logic [1:0][1:0][7:0]      gg;
        logic [1:0][1:0][3:0]      sfc;
        logic [1:0][1:0]           wsf, mixed, pre, sfs, c1;
        logic [1:0][1:0][1:0]      bt;
        logic [1:0][1:0][2:0][4:0] ts;
        logic [1:0][1:0][2:0][2:0] sbg;
        logic [1:0][1:0][3:0]      r0;
        logic [1:0][1:0][2:0]      r1;
    } si_t;

    logic clk = 1'b0;
    logic rst, start, axiid, axiiv;
    logic [8:0]                main_data_begin;
    logic [1:0][3:0]           scfsi;
    logic [1:0][1:0][11:0]     part2_3_length;
    logic [1:0][1:0][8:0]      big_values;
    logic [1:0][1:0][7:0]      global_gain;
    logic [1:0][1:0][3:0]      scalefac_compress;
    logic [1:0][1:0]           window_switching_flag, mixed_block_flag, preflag;
    logic [1:0][1:0]           scalefac_scale, count1table_select;
    logic [1:0][1:0][1:0]      block_type;
    logic [1:0][1:0][2:0][4:0] table_select;
    logic [1:0][1:0][2:0][2:0] subblock_gain;
    logic [1:0][1:0][3:0]      region0_count;
    logic [1:0][1:0][2:0]      region1_count;
    logic                      si_valid;

    side_info_parser dut (
        .clk(clk), .rst(rst), .start(start), .axiid(axiid), .axiiv(axiiv),
        .main_data_begin(main_data_begin), .scfsi(scfsi), .part2_3_length(part2_3_length),
        .big_values(big_values), .global_gain(global_gain), .scalefac_compress(scalefac_compress),
        .window_switching_flag(window_switching_flag), .mixed_block_flag(mixed_block_flag),
        .preflag(preflag), .scalefac_scale(scalefac_scale), .count1table_select(count1table_select),
        .block_type(block_type), .table_select(table_select), .subblock_gain(subblock_gain),
        .region0_count(region0_count), .region1_count(region1_count), .si_valid(si_valid)
    );

    always #5 clk = ~clk;

    int  n_checks = 0;
    int  n_errors = 0;
    int  cyc = 0;
    int  last_cyc = 0;
    int  n_valid = 0;
    int  n_pushed = 0;
    si_t exp_q[$];
    si_t zero_si, ones_si, cur;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic compare_si(input string ctx, input si_t e);
        check({ctx, ".mdb"},   64'(main_data_begin),       64'(e.mdb));
        check({ctx, ".scfsi"}, 64'(scfsi),                 64'(e.scfsi));
        check({ctx, ".p23"},   64'(part2_3_length),        64'(e.p23));
        check({ctx, ".bv"},    64'(big_values),            64'(e.bv));
        check({ctx, ".gg"},    64'(global_gain),           64'(e.gg));
        check({ctx, ".sfc"},   64'(scalefac_compress),     64'(e.sfc));
        check({ctx, ".wsf"},   64'(window_switching_flag), 64'(e.wsf));
        check({ctx, ".mixed"}, 64'(mixed_block_flag),      64'(e.mixed));
        check({ctx, ".pre"},   64'(preflag),               64'(e.pre));
        check({ctx, ".sfs"},   64'(scalefac_scale),        64'(e.sfs));
        check({ctx, ".c1"},    64'(count1table_select),    64'(e.c1));
        check({ctx, ".bt"},    64'(block_type),            64'(e.bt));
        check({ctx, ".ts"},    64'(table_select),          64'(e.ts));
        check({ctx, ".sbg"},   64'(subblock_gain),         64'(e.sbg));
        check({ctx, ".r0"},    64'(region0_count),         64'(e.r0));
        check({ctx, ".r1"},    64'(region1_count),         64'(e.r1));
    endtask

    // Scoreboard consumer: every si_valid must match a queued frame and its timing.
    always @(negedge clk) begin
        if (si_valid) begin
            n_valid++;
            check("si_valid_latency", 64'(cyc), 64'(last_cyc + 1));
            if (exp_q.size() == 0) begin
                check("spurious_si_valid", 64'(1), 64'(0));
            end else begin
                cur = exp_q.pop_front();
                compare_si("frame", cur);
            end
        end
    end

    // Fields that the frame does not carry for the chosen window mode read back as zero.
    function automatic si_t normalize(input si_t s);
        si_t r = s;
        for (int g = 0; g < 4; g++) begin
            if (r.wsf[g[1]][g[0]]) begin
                r.ts[g[1]][g[0]][2] = '0;
                r.r0[g[1]][g[0]] = '0;
                r.r1[g[1]][g[0]] = '0;
            end else begin
                r.bt[g[1]][g[0]] = '0;
                r.mixed[g[1]][g[0]] = '0;
                r.sbg[g[1]][g[0]] = '0;
            end
        end
        return r;
    endfunction

    function automatic si_t rand_si();
        si_t s;
        s.mdb = 9'($urandom);  s.scfsi = 8'($urandom);
        s.p23 = 48'({$urandom, $urandom}); s.bv = 36'({$urandom, $urandom});
        s.gg  = 32'($urandom); s.sfc = 16'($urandom);
        s.wsf = 4'($urandom);  s.mixed = 4'($urandom); s.pre = 4'($urandom);
        s.sfs = 4'($urandom);  s.c1 = 4'($urandom);    s.bt = 8'($urandom);
        s.ts  = 60'({$urandom, $urandom}); s.sbg = 36'({$urandom, $urandom});
        s.r0  = 16'($urandom); s.r1 = 12'($urandom);
        return normalize(s);
    endfunction

    task automatic put(inout logic [255:0] f, inout int p, input logic [15:0] v, input int w);
        for (int i = w - 1; i >= 0; i--) begin
            f[255 - p] = v[i];
            p++;
        end
    endtask

    task automatic encode(input si_t s, input logic [2:0] priv, output logic [255:0] f);
        int p = 0;
        f = '0;
        put(f, p, 16'(s.mdb), 9);
        put(f, p, 16'(priv), 3);
        put(f, p, 16'(s.scfsi[0]), 4);
        put(f, p, 16'(s.scfsi[1]), 4);
        for (int gr = 0; gr < 2; gr++) begin
            for (int ch = 0; ch < 2; ch++) begin
                put(f, p, 16'(s.p23[gr][ch]), 12);
                put(f, p, 16'(s.bv[gr][ch]), 9);
                put(f, p, 16'(s.gg[gr][ch]), 8);
                put(f, p, 16'(s.sfc[gr][ch]), 4);
                put(f, p, 16'(s.wsf[gr][ch]), 1);
                if (s.wsf[gr][ch]) begin
                    put(f, p, 16'(s.bt[gr][ch]), 2);
                    put(f, p, 16'(s.mixed[gr][ch]), 1);
                    for (int k = 0; k < 2; k++) put(f, p, 16'(s.ts[gr][ch][k]), 5);
                    for (int k = 0; k < 3; k++) put(f, p, 16'(s.sbg[gr][ch][k]), 3);
                end else begin
                    for (int k = 0; k < 3; k++) put(f, p, 16'(s.ts[gr][ch][k]), 5);
                    put(f, p, 16'(s.r0[gr][ch]), 4);
                    put(f, p, 16'(s.r1[gr][ch]), 3);
                end
                put(f, p, 16'(s.pre[gr][ch]), 1);
                put(f, p, 16'(s.sfs[gr][ch]), 1);
                put(f, p, 16'(s.c1[gr][ch]), 1);
            end
        end
        check("encode_length", 64'(p), 64'd256);
    endtask

    // gap_mode: 0 continuous, 1 alternate valid/idle, 2 random idle gaps.
    task automatic drive_frame(input logic [255:0] f, input int nbits, input int gap_mode,
                               input bit bit_on_start, input bit start_on_last);
        @(posedge clk); #1;
        start = 1'b1; axiiv = bit_on_start; axiid = ~f[255];
        for (int i = 0; i < nbits; i++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (gap_mode == 1 && i > 0) begin
                axiiv = 1'b0; axiid = 1'($urandom);
                @(posedge clk); #1;
            end else if (gap_mode == 2) begin
                repeat ($urandom_range(0, 3)) begin
                    axiiv = 1'b0; axiid = 1'($urandom);
                    @(posedge clk); #1;
                end
            end
            axiiv = 1'b1; axiid = f[255 - i];
            if (i == nbits - 1) begin
                last_cyc = cyc;
                start = start_on_last;
            end
        end
        @(posedge clk); #1;
        axiiv = 1'b0; start = 1'b0;
    endtask

    task automatic send(input si_t e, input logic [2:0] priv, input int gap_mode,
                        input bit bit_on_start, input bit start_on_last);
        logic [255:0] f;
        encode(e, priv, f);
        exp_q.push_back(e);
        n_pushed++;
        drive_frame(f, 256, gap_mode, bit_on_start, start_on_last);
        repeat (3) @(posedge clk);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [255:0] f;
        si_t a, b;
        zero_si = normalize(rand_si());
        zero_si = '{default: '0};
        rst = 1'b1; start = 1'b0; axiid = 1'b0; axiiv = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_si_valid", 64'(si_valid), 64'd0);
        compare_si("reset", zero_si);
        @(posedge clk); #1; rst = 1'b0;

        // All-zero frame, continuous valid.
        send(zero_si, 3'b000, 0, 1'b0, 1'b0);

        // Directed gr0/ch0 short-block frame, continuous then alternating valid.
        a = rand_si();
        a.mdb = 9'h1A5; a.scfsi[1] = 4'b1010;
        a.p23[0][0] = 12'h3C7; a.sfc[0][0] = 4'hF; a.wsf[0][0] = 1'b1;
        a.bt[0][0] = 2'd2; a.mixed[0][0] = 1'b0;
        a.sbg[0][0][0] = 3'd3; a.sbg[0][0][1] = 3'd5; a.sbg[0][0][2] = 3'd7;
        a = normalize(a);
        send(a, 3'b101, 0, 1'b0, 1'b0);
        send(a, 3'b101, 1, 1'b0, 1'b0);

        // Directed gr1/ch1 long-block fields; a valid bit alongside start must be dropped.
        b = rand_si();
        b.wsf[1][1] = 1'b0; b.ts[1][1][0] = 5'h11; b.ts[1][1][1] = 5'h05; b.ts[1][1][2] = 5'h1F;
        b.r0[1][1] = 4'hB; b.r1[1][1] = 3'd3; b.c1[1][1] = 1'b1;
        b = normalize(b);
        send(b, 3'b010, 0, 1'b1, 1'b0);

        // Random gaps, start coincident with the final bit, then stray bits in IDLE.
        cur = rand_si();
        send(cur, 3'($urandom), 2, 1'b0, 1'b1);
        repeat (10) begin
            @(posedge clk); #1; axiiv = 1'b1; axiid = 1'($urandom);
        end
        @(posedge clk); #1; axiiv = 1'b0;
        @(negedge clk);
        compare_si("idle_hold", cur);

        // Reset after 100 bits, then an all-ones frame.
        encode(rand_si(), 3'b000, f);
        drive_frame(f, 100, 0, 1'b0, 1'b0);
        @(posedge clk); #1; rst = 1'b1;
        @(negedge clk);
        check("midreset_si_valid", 64'(si_valid), 64'd0);
        compare_si("midreset", zero_si);
        @(posedge clk); #1; rst = 1'b0;
        ones_si = '{default: '1};
        ones_si = normalize(ones_si);
        send(ones_si, 3'b111, 0, 1'b0, 1'b0);
        check("ones_bt", 64'(block_type[1][0]), 64'd3);

        // Restart after 50 bits; only the second frame counts; trailing bits are ignored.
        encode(rand_si(), 3'b000, f);
        drive_frame(f, 50, 0, 1'b0, 1'b0);
        cur = rand_si();
        send(cur, 3'b011, 2, 1'b0, 1'b0);
        repeat (20) begin
            @(posedge clk); #1; axiiv = 1'b1; axiid = 1'($urandom);
        end
        @(posedge clk); #1; axiiv = 1'b0;
        repeat (3) @(negedge clk);
        compare_si("post_done_hold", cur);

        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        check("si_valid_count", 64'(n_valid), 64'(n_pushed));
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
